// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full adder is reused every clock, LSB first,
// with a carry flop closing the loop; reports {cout,sum} with a done pulse.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_cout;
    logic             load, last;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // start is only honoured outside SHIFT, so DONE can chain straight into a new op
    assign load = start && (state != SHIFT);
    assign last = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        // NOTE: next-state gets a default before any branch so no latch is inferred.
        state_nx = state;
        unique case (state)
            IDLE:    if (load) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = load ? SHIFT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nx;
            if (load) begin
                a_sh  <= a;
                b_sh  <= b;
                carry <= cin;
                cnt   <= '0;
                sum   <= '0;
                cout  <= 1'b0;
            end else if (state == SHIFT) begin
                sum   <= {fa_sum, sum[WIDTH-1:1]};
                a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                carry <= fa_cout;
                cnt   <= cnt + 1'b1;
                if (last) cout <= fa_cout;
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): reset, arithmetic, timing,
// ignored start while busy, back-to-back chaining, mid-op reset, operand sweep.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout;

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Drives one op from a negedge; returns at the negedge where done is seen.
    // lat counts negedges from the start-assert negedge; nbusy counts busy samples.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                          output logic [7:0] rs, output logic rc,
                          output int nbusy, output int lat);
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~ta; b = 8'h00; cin = ~tc;
        lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        rs = sum; rc = cout;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, cout, sum} !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: busy=%b done=%b cout=%b sum=%h, want all 0", i, busy, done, cout, sum);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, cout, sum} !== 11'd0) begin
                errors++;
                $display("FAIL reset_release cyc %0d: busy=%b done=%b cout=%b sum=%h, want all 0", i, busy, done, cout, sum);
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] rs; logic rc; int nb, lat;
        run_op(8'h5A, 8'h3C, 1'b0, rs, rc, nb, lat);
        checks++;
        if (lat !== 9 || nb !== 8) begin
            errors++;
            $display("FAIL basic_timing: lat=%0d busy_cycles=%0d, want 9 and 8", lat, nb);
        end
        checks++;
        if ({rc, rs} !== 9'h096) begin
            errors++;
            $display("FAIL basic_result: got %b_%h, want 0_96", rc, rs);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h96) begin
            errors++;
            $display("FAIL basic_after_done: done=%b busy=%b sum=%h, want 0 0 96", done, busy, sum);
        end
    endtask

    task automatic test_carry_chain;
        logic [7:0] rs; logic rc; int nb, lat;
        run_op(8'hFF, 8'h01, 1'b0, rs, rc, nb, lat);
        checks++;
        if ({rc, rs} !== 9'h100) begin
            errors++;
            $display("FAIL carry_ff_01: got %b_%h, want 1_00", rc, rs);
        end
        run_op(8'hFF, 8'hFF, 1'b1, rs, rc, nb, lat);
        checks++;
        if ({rc, rs} !== 9'h1FF) begin
            errors++;
            $display("FAIL carry_ff_ff_1: got %b_%h, want 1_ff", rc, rs);
        end
        run_op(8'hFF, 8'h00, 1'b1, rs, rc, nb, lat);
        checks++;
        if ({rc, rs} !== 9'h100) begin
            errors++;
            $display("FAIL wrap_ff_00_1: got %b_%h, want 1_00", rc, rs);
        end
    endtask

    task automatic test_ignore_busy;
        int lat;
        @(negedge clk);
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == 3) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL ignore_latency: done after %0d cycles, want 9", lat);
        end
        checks++;
        if ({cout, sum} !== 9'h002) begin
            errors++;
            $display("FAIL ignore_result: got %b_%h, want 0_02", cout, sum);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_not_queued: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] rs; logic rc; int nb, lat;
        run_op(8'h5A, 8'h3C, 1'b0, rs, rc, nb, lat);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        checks++;
        if (done !== 1'b1 || sum !== 8'h96) begin
            errors++;
            $display("FAIL b2b_prev_visible: done=%b sum=%h, want 1 96", done, sum);
        end
        @(negedge clk);
        start = 1'b0; a = 8'hEE; b = 8'hEE;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: busy=%b done=%b, want 1 0", busy, done);
        end
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 9 || {cout, sum} !== 9'h030) begin
            errors++;
            $display("FAIL b2b_result: lat=%0d got %b_%h, want 9 0_30", lat, cout, sum);
        end
    endtask

    task automatic test_reset_mid;
        int seen_done;
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid_async: busy=%b done=%b cout=%b sum=%h, want all 0", busy, done, cout, sum);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen_done++;
        end
        checks++;
        if (seen_done !== 0 || sum !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_quiet: active_cycles=%0d sum=%h, want 0 00", seen_done, sum);
        end
    endtask

    task automatic test_sweep;
        logic [7:0] rs; logic rc; int nb, lat;
        logic [7:0] bvals [4];
        logic [8:0] exp;
        bvals[0] = 8'h00; bvals[1] = 8'h01; bvals[2] = 8'hFF; bvals[3] = 8'h5A;
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    exp = 9'(ai) + 9'(bvals[bi]) + 9'(ci);
                    run_op(8'(ai), bvals[bi], 1'(ci), rs, rc, nb, lat);
                    checks++;
                    if ({rc, rs} !== exp || lat !== 9) begin
                        errors++;
                        $display("FAIL sweep a=%h b=%h cin=%0d: got %b_%h lat=%0d, want %b_%h lat=9",
                                 8'(ai), bvals[bi], ci, rc, rs, lat, exp[8], exp[7:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_carry_chain;
        test_ignore_busy;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
